freq_meter: RTL and testbench
=============================

FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 Parameter GATE_CYCLES, default 100000000, gate window length in clk cycles (minimum 2).
REQ-002 Parameter CNT_W, default 16, result width in bits.
REQ-003 clk  input  1  system clock; all state is updated on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 sig_in  input  1  signal to be measured; asynchronous to clk (e.g. an output of a divided clock).
REQ-006 start  input  1  one-cycle request to begin a measurement.
REQ-007 cont  input  1  continuous mode; when 1, a new gate begins immediately after each result.
REQ-008 count  output  CNT_W  number of sig_in rising edges counted in the last completed gate.
REQ-009 valid  output  1  one-cycle pulse when count and overflow are updated.
REQ-010 overflow  output  1  set when the last gate saw more than 2^CNT_W-1 edges.
REQ-011 busy  output  1  high while a gate window is open.

Function
REQ-012 sig_in SHALL pass through a two-flop synchronizer, followed by a third flop used for rising-edge detection.
REQ-013 The edge pulse SHALL be asserted for one clk cycle, 3 cycles after sig_in rises, for each rising edge of sig_in held stable at least 2 clk cycles.
REQ-014 FSM states: IDLE, GATE, DONE; reset state is IDLE.
REQ-015 IDLE -> GATE on start=1, or on cont=1; gate counter cleared to 0; edge accumulator cleared to 0.
REQ-016 In GATE, the gate counter SHALL increment every cycle; an edge pulse present in any GATE cycle SHALL increment the accumulator.
REQ-017 GATE -> DONE in the cycle the gate counter equals GATE_CYCLES-1, so a gate spans exactly GATE_CYCLES cycles.
REQ-018 An edge pulse in that final GATE cycle SHALL be counted.
REQ-019 The accumulator SHALL saturate at 2^CNT_W-1 and set an internal overflow flag instead of wrapping.
REQ-020 In DONE (one cycle), count <= accumulator, overflow <= flag, and valid=1.
REQ-021 DONE -> GATE if cont=1, starting a new window with no gap cycles and with the accumulator and flag cleared; otherwise DONE -> IDLE.
REQ-022 start SHALL be ignored in GATE and DONE; it is not queued.
REQ-023 Deasserting cont during GATE SHALL NOT abort the gate; the FSM returns to IDLE after that gate's DONE.
REQ-024 busy=1 exactly in GATE; valid=1 exactly in DONE.
REQ-025 count and overflow SHALL hold their values between valid pulses.
REQ-026 Edges arriving while in IDLE or DONE SHALL NOT be counted.

Reset
REQ-027 On rst_n=0, immediately: FSM=IDLE; count=0; overflow=0; valid=0; busy=0; gate counter, accumulator, flag, and synchronizer flops all cleared to 0.
REQ-028 A reset asserted mid-gate SHALL discard the partial measurement and produce no valid pulse.
REQ-029 After rst_n deasserts, no measurement begins until start=1 or cont=1.

Verification (GATE_CYCLES=100, CNT_W=16 unless stated)
REQ-030 sig_in is a square wave of period 10 clk, phase-aligned so no edge pulse falls on a window boundary; pulse start once -> busy for 100 cycles, then one valid with count=10, overflow=0, then IDLE.
REQ-031 sig_in held at 0, start pulsed -> valid with count=0; sig_in rise timed so its edge pulse lands in the last GATE cycle -> count=1.
REQ-032 CNT_W=3, sig_in period 4 clk (25 edges), start pulsed -> count=7, overflow=1; next gate with sig_in=0 -> count=0, overflow=0.
REQ-033 cont=1 held, sig_in period 20 -> valid every 101 cycles, each with count=5; cont dropped mid-gate -> exactly one more valid, then busy=0.
REQ-034 rst_n pulsed low at cycle 50 of a gate -> all outputs 0 immediately; no valid follows; a subsequent start produces a correct full 100-cycle result.
REQ-035 start pulsed during GATE and during DONE -> ignored; exactly one valid is produced per accepted start.

Source files
------------

// File: rtl/freq_meter.sv
// Counts sig_in rising edges over a GATE_CYCLES-long window; result and valid appear together
// in the DONE cycle, 3 cycles of synchronizer latency on sig_in. No backpressure: valid is a single pulse.
module freq_meter #(
    parameter int GATE_CYCLES = 100000000,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             start,
    input  logic             cont,
    output logic [CNT_W-1:0] count,
    output logic             valid,
    output logic             overflow,
    output logic             busy
);

    localparam int              GW      = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0]   LAST    = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACC_MAX = '1;

    typedef enum logic [1:0] {IDLE, GATE, DONE} state_t;

    state_t           state, state_nxt;
    logic             sync1, sync2, sync3;
    logic             edge_pulse;
    logic [GW-1:0]    gate_cnt;
    logic [CNT_W-1:0] acc, acc_nxt;
    logic             acc_ovf, ovf_nxt;
    logic             gate_last;

    assign edge_pulse = sync2 & ~sync3;
    assign gate_last  = (gate_cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start || cont) state_nxt = GATE;
            GATE:    if (gate_last) state_nxt = DONE;
            DONE:    state_nxt = cont ? GATE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy  = 1'b0;
        valid = 1'b0;
        case (state)
            GATE:    busy  = 1'b1;
            DONE:    valid = 1'b1;
            default: ;
        endcase
    end

    // Saturating accumulate; the flag records that at least one edge was lost.
    always_comb begin
        acc_nxt = acc;
        ovf_nxt = acc_ovf;
        if (edge_pulse) begin
            if (acc == ACC_MAX) begin
                ovf_nxt = 1'b1;
            end else begin
                acc_nxt = acc + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            sync3    <= 1'b0;
            gate_cnt <= '0;
            acc      <= '0;
            acc_ovf  <= 1'b0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            sync1 <= sig_in;
            sync2 <= sync1;
            sync3 <= sync2;
            case (state)
                GATE: begin
                    gate_cnt <= gate_cnt + GW'(1);
                    acc      <= acc_nxt;
                    acc_ovf  <= ovf_nxt;
                    // Load on the final gate cycle so the result is already present while valid is high.
                    if (gate_last) begin
                        count    <= acc_nxt;
                        overflow <= ovf_nxt;
                    end
                end
                default: begin
                    gate_cnt <= '0;
                    acc      <= '0;
                    acc_ovf  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: table of square-wave periods plus hand-timed corner sequences.
module tb_freq_meter;

    logic        clk;
    logic        rst_n;
    logic        sig_in;
    logic        start;
    logic        cont;
    logic [15:0] count;
    logic        valid, overflow, busy;
    logic [2:0]  count3;
    logic        valid3, overflow3, busy3;

    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          cyc = 0;
    int          sig_period = 0;
    logic        sig_manual = 1'b0;

    freq_meter #(.GATE_CYCLES(100), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .start(start), .cont(cont),
        .count(count), .valid(valid), .overflow(overflow), .busy(busy)
    );

    freq_meter #(.GATE_CYCLES(100), .CNT_W(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .start(start), .cont(cont),
        .count(count3), .valid(valid3), .overflow(overflow3), .busy(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Square wave generator, driven 2 time units after each rising clk edge.
    initial begin
        int ph;
        int last_p;
        ph = 0;
        last_p = -1;
        sig_in = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (sig_period != last_p) begin
                ph = 0;
                last_p = sig_period;
            end
            if (sig_period == 0) begin
                sig_in = sig_manual;
            end else begin
                sig_in = (ph < sig_period / 2);
                ph = (ph + 1 == sig_period) ? 0 : ph + 1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic chk(input string name, input longint act, input longint exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d required %0d", name, act, exp);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_valid(input int limit, output bit found, output int busy_cyc);
        found = 1'b0;
        busy_cyc = 0;
        for (int k = 0; k < limit && !found; k++) begin
            @(negedge clk);
            if (valid) found = 1'b1;
            else if (busy) busy_cyc++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    typedef struct {
        int period;
        int exp_cnt;
        bit exp_ovf;
        int exp_cnt3;
        bit exp_ovf3;
    } vec_t;

    vec_t vecs[6];

    initial begin
        bit found;
        int bc;
        int t1, t2;
        string nm;

        vecs[0] = '{10, 10, 1'b0, 7, 1'b1};
        vecs[1] = '{20,  5, 1'b0, 5, 1'b0};
        vecs[2] = '{ 4, 25, 1'b0, 7, 1'b1};
        vecs[3] = '{ 0,  0, 1'b0, 0, 1'b0};
        vecs[4] = '{50,  2, 1'b0, 2, 1'b0};
        vecs[5] = '{25,  4, 1'b0, 4, 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        cont  = 1'b0;
        #22;
        chk("reset_count", count, 0);
        chk("reset_valid", valid, 0);
        chk("reset_overflow", overflow, 0);
        chk("reset_busy", busy, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        wait_valid(150, found, bc);
        chk("no_start_no_valid", found, 0);
        chk("no_start_no_busy", bc, 0);

        for (int v = 0; v < 6; v++) begin
            sig_period = vecs[v].period;
            idle(2 * vecs[v].period + 8);
            pulse_start();
            wait_valid(300, found, bc);
            nm = $sformatf("p%0d", vecs[v].period);
            chk({nm, "_valid"}, found, 1);
            chk({nm, "_busy_len"}, bc, 100);
            chk({nm, "_count"}, count, vecs[v].exp_cnt);
            chk({nm, "_ovf"}, overflow, vecs[v].exp_ovf);
            chk({nm, "_valid3"}, valid3, 1);
            chk({nm, "_count3"}, count3, vecs[v].exp_cnt3);
            chk({nm, "_ovf3"}, overflow3, vecs[v].exp_ovf3);
            repeat (5) @(negedge clk);
            chk({nm, "_hold_count"}, count, vecs[v].exp_cnt);
            chk({nm, "_hold_ovf3"}, overflow3, vecs[v].exp_ovf3);
            chk({nm, "_idle_after"}, {busy, valid}, 0);
        end

        // Rising edge whose pulse lands in the last gate cycle is counted.
        sig_period = 0;
        sig_manual = 1'b0;
        idle(10);
        pulse_start();
        repeat (97) @(posedge clk);
        #1 sig_manual = 1'b1;
        wait_valid(300, found, bc);
        chk("last_cycle_edge_valid", found, 1);
        chk("last_cycle_edge_count", count, 1);

        // One cycle later the pulse falls in DONE and is dropped.
        sig_manual = 1'b0;
        idle(10);
        pulse_start();
        repeat (98) @(posedge clk);
        #1 sig_manual = 1'b1;
        wait_valid(300, found, bc);
        chk("done_cycle_edge_valid", found, 1);
        chk("done_cycle_edge_count", count, 0);
        sig_manual = 1'b0;

        // Continuous mode: back-to-back windows, then cont dropped mid-gate.
        sig_period = 20;
        idle(45);
        cont = 1'b1;
        wait_valid(300, found, bc);
        chk("cont_v1_found", found, 1);
        chk("cont_v1_count", count, 5);
        t1 = cyc;
        for (int n = 2; n <= 3; n++) begin
            wait_valid(300, found, bc);
            t2 = cyc;
            chk($sformatf("cont_v%0d_found", n), found, 1);
            chk($sformatf("cont_v%0d_spacing", n), t2 - t1, 101);
            chk($sformatf("cont_v%0d_count", n), count, 5);
            t1 = t2;
        end
        idle(30);
        cont = 1'b0;
        wait_valid(300, found, bc);
        t2 = cyc;
        chk("cont_last_found", found, 1);
        chk("cont_last_spacing", t2 - t1, 101);
        chk("cont_last_count", count, 5);
        wait_valid(300, found, bc);
        chk("cont_stopped_no_valid", found, 0);
        chk("cont_stopped_no_busy", bc, 0);

        // start during GATE and during DONE is ignored.
        sig_period = 10;
        idle(25);
        pulse_start();
        repeat (39) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_valid(300, found, bc);
        chk("ign_valid", found, 1);
        chk("ign_count", count, 10);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_valid(300, found, bc);
        chk("ign_no_second_valid", found, 0);
        chk("ign_no_second_busy", bc, 0);

        // Reset in the middle of a gate.
        idle(5);
        pulse_start();
        repeat (49) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_count", count, 0);
        chk("midrst_overflow", overflow, 0);
        chk("midrst_valid", valid, 0);
        chk("midrst_busy", busy, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        wait_valid(200, found, bc);
        chk("midrst_no_valid", found, 0);
        chk("midrst_no_busy", bc, 0);
        pulse_start();
        wait_valid(300, found, bc);
        chk("postrst_valid", found, 1);
        chk("postrst_busy_len", bc, 100);
        chk("postrst_count", count, 10);
        chk("postrst_ovf", overflow, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
